// File: rtl/mflushpwr_ctrl_if.sv
// Handshake bundle between the flush/power-down controller and its CSR, L2 and
// power-controller neighbours. The slave modport is the controller's view.
interface mflushpwr_ctrl_if;
   logic       io_req_valid;
   logic       io_req_ready;
   logic [7:0] io_coreid;
   logic       io_l2_flush_req;
   logic       io_l2_flush_done;
   logic       io_pwr_req;
   logic       io_pwr_ack;
   logic       io_busy;
   logic       io_diff_valid;
   logic       io_diff_l2FlushDone;
   logic [7:0] io_diff_coreid;

   modport master (
      output io_req_valid, io_coreid, io_l2_flush_done, io_pwr_ack,
      input  io_req_ready, io_l2_flush_req, io_pwr_req, io_busy,
             io_diff_valid, io_diff_l2FlushDone, io_diff_coreid
   );

   modport slave (
      input  io_req_valid, io_coreid, io_l2_flush_done, io_pwr_ack,
      output io_req_ready, io_l2_flush_req, io_pwr_req, io_busy,
             io_diff_valid, io_diff_l2FlushDone, io_diff_coreid
   );
endinterface

// File: rtl/mflushpwr_ctrl.sv
// Flush-then-power-down sequencer: flushes L2 (with timeout), optionally
// handshakes with the power controller, then emits one difftest event.
module mflushpwr_ctrl #(
   parameter logic [15:0] TIMEOUT    = 16'd4096,
   parameter bit          PWR_ACK_EN = 1'b1
) (
   input logic             clock,
   input logic             reset,
   mflushpwr_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FLUSH, PWR, REPORT} state_t;

   localparam logic [15:0] LAST_CNT = TIMEOUT - 16'd1;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic        done_flag;
   logic        done_flag_nxt;
   logic [7:0]  coreid_q;
   logic        diff_done_q;
   logic [7:0]  diff_id_q;

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         done_flag   <= 1'b0;
         coreid_q    <= '0;
         diff_done_q <= 1'b0;
         diff_id_q   <= '0;
      end else begin
         state     <= state_nxt;
         done_flag <= done_flag_nxt;
         if (state == IDLE && bus.io_req_valid) begin
            coreid_q <= bus.io_coreid;
            cnt      <= '0;
         end else if (state == FLUSH) begin
            cnt <= cnt + 16'd1;
         end
         // Event fields are latched on REPORT entry so they hold across the next request.
         if (state_nxt == REPORT) begin
            diff_done_q <= done_flag_nxt;
            diff_id_q   <= coreid_q;
         end
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can infer a latch.
   always_comb begin
      state_nxt     = state;
      done_flag_nxt = done_flag;
      unique case (state)
         IDLE: begin
            if (bus.io_req_valid) state_nxt = FLUSH;
         end
         FLUSH: begin
            // Done is tested first so it wins over a coincident timeout.
            if (bus.io_l2_flush_done) begin
               done_flag_nxt = 1'b1;
               state_nxt     = PWR_ACK_EN ? PWR : REPORT;
            end else if (cnt == LAST_CNT) begin
               done_flag_nxt = 1'b0;
               state_nxt     = REPORT;
            end
         end
         PWR: begin
            if (bus.io_pwr_ack) state_nxt = REPORT;
         end
         REPORT: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.io_req_ready    = (state == IDLE);
      bus.io_busy         = (state != IDLE);
      bus.io_l2_flush_req = (state == FLUSH);
      bus.io_pwr_req      = (state == PWR);
      bus.io_diff_valid   = (state == REPORT);
   end

   assign bus.io_diff_l2FlushDone = diff_done_q;
   assign bus.io_diff_coreid      = diff_id_q;

endmodule

// File: tb/tb_mflushpwr_ctrl.sv
// Directed bench for mflushpwr_ctrl: dut_a has the power handshake, dut_b skips it;
// both use TIMEOUT=16 so the timeout path is short.
module tb_mflushpwr_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulses_a = 0;
   int   pulses_b = 0;

   mflushpwr_ctrl_if bus_a ();
   mflushpwr_ctrl_if bus_b ();

   mflushpwr_ctrl #(.TIMEOUT(16'd16), .PWR_ACK_EN(1'b1)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a)
   );
   mflushpwr_ctrl #(.TIMEOUT(16'd16), .PWR_ACK_EN(1'b0)) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (bus_a.io_diff_valid) pulses_a++;
      if (bus_b.io_diff_valid) pulses_b++;
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      n_cmp++; if (bus_a.io_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus_a.io_req_ready); end
      n_cmp++; if (bus_a.io_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus_a.io_busy); end
      n_cmp++; if (bus_a.io_l2_flush_req !== 1'b0) begin n_bad++; $display("FAIL reset_flush_req: got %b want 0", bus_a.io_l2_flush_req); end
      n_cmp++; if (bus_a.io_pwr_req !== 1'b0) begin n_bad++; $display("FAIL reset_pwr_req: got %b want 0", bus_a.io_pwr_req); end
      n_cmp++; if (bus_a.io_diff_valid !== 1'b0) begin n_bad++; $display("FAIL reset_diff_valid: got %b want 0", bus_a.io_diff_valid); end
      n_cmp++; if (bus_a.io_diff_l2FlushDone !== 1'b0) begin n_bad++; $display("FAIL reset_diff_done: got %b want 0", bus_a.io_diff_l2FlushDone); end
      n_cmp++; if (bus_a.io_diff_coreid !== 8'h00) begin n_bad++; $display("FAIL reset_diff_id: got %h want 00", bus_a.io_diff_coreid); end
      n_cmp++; if (bus_b.io_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_b: got %b want 1", bus_b.io_req_ready); end
      reset = 1'b0;
      step(1);
      n_cmp++; if (bus_a.io_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", bus_a.io_busy); end
   endtask

   task automatic test_stray_inputs();
      int p0;
      p0 = pulses_a;
      bus_a.io_l2_flush_done = 1'b1;
      bus_a.io_pwr_ack       = 1'b1;
      step(3);
      bus_a.io_l2_flush_done = 1'b0;
      bus_a.io_pwr_ack       = 1'b0;
      n_cmp++; if (bus_a.io_req_ready !== 1'b1) begin n_bad++; $display("FAIL stray_ready: got %b want 1", bus_a.io_req_ready); end
      n_cmp++; if (bus_a.io_busy !== 1'b0) begin n_bad++; $display("FAIL stray_busy: got %b want 0", bus_a.io_busy); end
      step(1);
      n_cmp++; if (pulses_a - p0 !== 0) begin n_bad++; $display("FAIL stray_pulses: got %0d want 0", pulses_a - p0); end
   endtask

   task automatic test_nominal();
      int p0;
      p0 = pulses_a;
      bus_a.io_req_valid = 1'b1;
      bus_a.io_coreid    = 8'h03;
      step(1);
      bus_a.io_req_valid = 1'b0;
      bus_a.io_coreid    = 8'hFF;
      n_cmp++; if (bus_a.io_l2_flush_req !== 1'b1) begin n_bad++; $display("FAIL nom_flush_req: got %b want 1", bus_a.io_l2_flush_req); end
      n_cmp++; if (bus_a.io_busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy: got %b want 1", bus_a.io_busy); end
      n_cmp++; if (bus_a.io_req_ready !== 1'b0) begin n_bad++; $display("FAIL nom_ready: got %b want 0", bus_a.io_req_ready); end
      step(4);
      bus_a.io_l2_flush_done = 1'b1;
      step(1);
      bus_a.io_l2_flush_done = 1'b0;
      n_cmp++; if (bus_a.io_pwr_req !== 1'b1) begin n_bad++; $display("FAIL nom_pwr_req: got %b want 1", bus_a.io_pwr_req); end
      n_cmp++; if (bus_a.io_l2_flush_req !== 1'b0) begin n_bad++; $display("FAIL nom_flush_drop: got %b want 0", bus_a.io_l2_flush_req); end
      step(1);
      n_cmp++; if (bus_a.io_pwr_req !== 1'b1) begin n_bad++; $display("FAIL nom_pwr_hold: got %b want 1", bus_a.io_pwr_req); end
      bus_a.io_pwr_ack = 1'b1;
      step(1);
      bus_a.io_pwr_ack = 1'b0;
      n_cmp++; if (bus_a.io_diff_valid !== 1'b1) begin n_bad++; $display("FAIL nom_diff_valid: got %b want 1", bus_a.io_diff_valid); end
      n_cmp++; if (bus_a.io_diff_l2FlushDone !== 1'b1) begin n_bad++; $display("FAIL nom_diff_done: got %b want 1", bus_a.io_diff_l2FlushDone); end
      n_cmp++; if (bus_a.io_diff_coreid !== 8'h03) begin n_bad++; $display("FAIL nom_diff_id: got %h want 03", bus_a.io_diff_coreid); end
      n_cmp++; if (bus_a.io_pwr_req !== 1'b0) begin n_bad++; $display("FAIL nom_pwr_drop: got %b want 0", bus_a.io_pwr_req); end
      step(1);
      n_cmp++; if (bus_a.io_diff_valid !== 1'b0) begin n_bad++; $display("FAIL nom_diff_one_cycle: got %b want 0", bus_a.io_diff_valid); end
      n_cmp++; if (bus_a.io_diff_coreid !== 8'h03) begin n_bad++; $display("FAIL nom_diff_id_hold: got %h want 03", bus_a.io_diff_coreid); end
      n_cmp++; if (bus_a.io_req_ready !== 1'b1) begin n_bad++; $display("FAIL nom_back_idle: got %b want 1", bus_a.io_req_ready); end
      n_cmp++; if (pulses_a - p0 !== 1) begin n_bad++; $display("FAIL nom_pulses: got %0d want 1", pulses_a - p0); end
   endtask

   task automatic test_timeout(input logic [7:0] id);
      int p0;
      int flush_cycles;
      bit pwr_seen;
      bit got;
      p0           = pulses_a;
      flush_cycles = 0;
      pwr_seen     = 1'b0;
      got          = 1'b0;
      bus_a.io_req_valid = 1'b1;
      bus_a.io_coreid    = id;
      step(1);
      bus_a.io_req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus_a.io_l2_flush_req) flush_cycles++;
         if (bus_a.io_pwr_req) pwr_seen = 1'b1;
         if (bus_a.io_diff_valid) begin
            got = 1'b1;
            break;
         end
         step(1);
      end
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL to_no_report: got %b want 1 within 40 cycles", got); end
      n_cmp++; if (flush_cycles !== 16) begin n_bad++; $display("FAIL to_flush_cycles: got %0d want 16", flush_cycles); end
      n_cmp++; if (pwr_seen !== 1'b0) begin n_bad++; $display("FAIL to_pwr_seen: got %b want 0", pwr_seen); end
      n_cmp++; if (bus_a.io_diff_l2FlushDone !== 1'b0) begin n_bad++; $display("FAIL to_diff_done: got %b want 0", bus_a.io_diff_l2FlushDone); end
      n_cmp++; if (bus_a.io_diff_coreid !== id) begin n_bad++; $display("FAIL to_diff_id: got %h want %h", bus_a.io_diff_coreid, id); end
      step(1);
      n_cmp++; if (pulses_a - p0 !== 1) begin n_bad++; $display("FAIL to_pulses: got %0d want 1", pulses_a - p0); end
   endtask

   task automatic test_simultaneous();
      bus_a.io_req_valid = 1'b1;
      bus_a.io_coreid    = 8'h77;
      step(1);
      bus_a.io_req_valid = 1'b0;
      step(15);
      n_cmp++; if (bus_a.io_l2_flush_req !== 1'b1) begin n_bad++; $display("FAIL sim_still_flush: got %b want 1", bus_a.io_l2_flush_req); end
      bus_a.io_l2_flush_done = 1'b1;
      step(1);
      bus_a.io_l2_flush_done = 1'b0;
      n_cmp++; if (bus_a.io_pwr_req !== 1'b1) begin n_bad++; $display("FAIL sim_pwr_entered: got %b want 1", bus_a.io_pwr_req); end
      n_cmp++; if (bus_a.io_diff_valid !== 1'b0) begin n_bad++; $display("FAIL sim_no_early_report: got %b want 0", bus_a.io_diff_valid); end
      bus_a.io_pwr_ack = 1'b1;
      step(1);
      bus_a.io_pwr_ack = 1'b0;
      n_cmp++; if (bus_a.io_diff_valid !== 1'b1) begin n_bad++; $display("FAIL sim_diff_valid: got %b want 1", bus_a.io_diff_valid); end
      n_cmp++; if (bus_a.io_diff_l2FlushDone !== 1'b1) begin n_bad++; $display("FAIL sim_diff_done: got %b want 1", bus_a.io_diff_l2FlushDone); end
      n_cmp++; if (bus_a.io_diff_coreid !== 8'h77) begin n_bad++; $display("FAIL sim_diff_id: got %h want 77", bus_a.io_diff_coreid); end
      step(1);
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = pulses_a;
      bus_a.io_req_valid = 1'b1;
      bus_a.io_coreid    = 8'h11;
      step(1);
      bus_a.io_coreid = 8'h22;
      n_cmp++; if (bus_a.io_req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_flush: got %b want 0", bus_a.io_req_ready); end
      bus_a.io_l2_flush_done = 1'b1;
      step(1);
      bus_a.io_l2_flush_done = 1'b0;
      n_cmp++; if (bus_a.io_req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_pwr: got %b want 0", bus_a.io_req_ready); end
      bus_a.io_pwr_ack = 1'b1;
      step(1);
      bus_a.io_pwr_ack = 1'b0;
      n_cmp++; if (bus_a.io_diff_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_first_valid: got %b want 1", bus_a.io_diff_valid); end
      n_cmp++; if (bus_a.io_diff_coreid !== 8'h11) begin n_bad++; $display("FAIL b2b_first_id: got %h want 11", bus_a.io_diff_coreid); end
      n_cmp++; if (bus_a.io_req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_report: got %b want 0", bus_a.io_req_ready); end
      step(1);
      n_cmp++; if (bus_a.io_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_ready: got %b want 1", bus_a.io_req_ready); end
      step(1);
      bus_a.io_req_valid = 1'b0;
      n_cmp++; if (bus_a.io_l2_flush_req !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: got %b want 1", bus_a.io_l2_flush_req); end
      n_cmp++; if (bus_a.io_diff_coreid !== 8'h11) begin n_bad++; $display("FAIL b2b_id_hold: got %h want 11", bus_a.io_diff_coreid); end
      bus_a.io_l2_flush_done = 1'b1;
      step(1);
      bus_a.io_l2_flush_done = 1'b0;
      bus_a.io_pwr_ack       = 1'b1;
      step(1);
      bus_a.io_pwr_ack = 1'b0;
      n_cmp++; if (bus_a.io_diff_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_second_valid: got %b want 1", bus_a.io_diff_valid); end
      n_cmp++; if (bus_a.io_diff_coreid !== 8'h22) begin n_bad++; $display("FAIL b2b_second_id: got %h want 22", bus_a.io_diff_coreid); end
      step(1);
      n_cmp++; if (pulses_a - p0 !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses_a - p0); end
      n_cmp++; if (bus_a.io_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_final_busy: got %b want 0", bus_a.io_busy); end
   endtask

   task automatic test_reset_mid_flush();
      int p0;
      p0 = pulses_a;
      bus_a.io_req_valid = 1'b1;
      bus_a.io_coreid    = 8'h99;
      step(1);
      bus_a.io_req_valid = 1'b0;
      step(7);
      n_cmp++; if (bus_a.io_l2_flush_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_flushing: got %b want 1", bus_a.io_l2_flush_req); end
      reset = 1'b1;
      step(1);
      n_cmp++; if (bus_a.io_l2_flush_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flush_req: got %b want 0", bus_a.io_l2_flush_req); end
      n_cmp++; if (bus_a.io_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", bus_a.io_req_ready); end
      n_cmp++; if (bus_a.io_diff_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_diff_valid: got %b want 0", bus_a.io_diff_valid); end
      n_cmp++; if (bus_a.io_diff_coreid !== 8'h00) begin n_bad++; $display("FAIL rst_mid_diff_id: got %h want 00", bus_a.io_diff_coreid); end
      reset = 1'b0;
      step(2);
      n_cmp++; if (pulses_a - p0 !== 0) begin n_bad++; $display("FAIL rst_mid_pulses: got %0d want 0", pulses_a - p0); end
      test_timeout(8'h3C);
   endtask

   task automatic test_no_pwr();
      int p0;
      p0 = pulses_b;
      bus_b.io_req_valid = 1'b1;
      bus_b.io_coreid    = 8'h42;
      step(1);
      bus_b.io_req_valid = 1'b0;
      n_cmp++; if (bus_b.io_l2_flush_req !== 1'b1) begin n_bad++; $display("FAIL nopwr_flush_req: got %b want 1", bus_b.io_l2_flush_req); end
      bus_b.io_l2_flush_done = 1'b1;
      step(1);
      bus_b.io_l2_flush_done = 1'b0;
      n_cmp++; if (bus_b.io_diff_valid !== 1'b1) begin n_bad++; $display("FAIL nopwr_diff_valid: got %b want 1", bus_b.io_diff_valid); end
      n_cmp++; if (bus_b.io_diff_l2FlushDone !== 1'b1) begin n_bad++; $display("FAIL nopwr_diff_done: got %b want 1", bus_b.io_diff_l2FlushDone); end
      n_cmp++; if (bus_b.io_diff_coreid !== 8'h42) begin n_bad++; $display("FAIL nopwr_diff_id: got %h want 42", bus_b.io_diff_coreid); end
      n_cmp++; if (bus_b.io_pwr_req !== 1'b0) begin n_bad++; $display("FAIL nopwr_pwr_req: got %b want 0", bus_b.io_pwr_req); end
      step(1);
      n_cmp++; if (bus_b.io_diff_valid !== 1'b0) begin n_bad++; $display("FAIL nopwr_one_cycle: got %b want 0", bus_b.io_diff_valid); end
      n_cmp++; if (bus_b.io_req_ready !== 1'b1) begin n_bad++; $display("FAIL nopwr_idle: got %b want 1", bus_b.io_req_ready); end
      n_cmp++; if (pulses_b - p0 !== 1) begin n_bad++; $display("FAIL nopwr_pulses: got %0d want 1", pulses_b - p0); end
   endtask

   initial begin
      bus_a.io_req_valid = 1'b0; bus_a.io_coreid = 8'h00;
      bus_a.io_l2_flush_done = 1'b0; bus_a.io_pwr_ack = 1'b0;
      bus_b.io_req_valid = 1'b0; bus_b.io_coreid = 8'h00;
      bus_b.io_l2_flush_done = 1'b0; bus_b.io_pwr_ack = 1'b0;

      test_reset();
      test_stray_inputs();
      test_nominal();
      test_timeout(8'h5A);
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_flush();
      test_no_pwr();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule
